// File: rtl/grid_tick_scheduler.sv
// grid_tick_scheduler
// Frame-rate sequencer for the 160-column bullet shifter grid. Divides the
// system clock into game ticks; on each accepted tick it loads any pending
// player/enemy shot into the grid, issues one shift pulse, then hands the
// frame to the VGA drawer through a start/done handshake.
module grid_tick_scheduler #(
  parameter int TICK_DIV     = 833333,
  parameter int COOLDOWN     = 8,
  parameter int ENEMY_PERIOD = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       shoot,
  input  logic [7:0] user_x,
  input  logic [7:0] enemy_x,
  input  logic       enemy_alive,
  input  logic       draw_done,
  output logic       gridUpdateEn,
  output logic       load_en,
  output logic [7:0] load_x,
  output logic       load_top,
  output logic       draw_start,
  output logic       busy,
  output logic [7:0] overrun_cnt
);

  // Counter widths, kept at least one bit wide for degenerate parameters.
  localparam int DIV_W  = (TICK_DIV > 2)     ? $clog2(TICK_DIV)     : 1;
  localparam int COOL_W = (COOLDOWN > 1)     ? $clog2(COOLDOWN + 1) : 1;
  localparam int EN_W   = (ENEMY_PERIOD > 2) ? $clog2(ENEMY_PERIOD) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(COOLDOWN);
  localparam logic [EN_W-1:0]   EN_LOAD   = EN_W'(ENEMY_PERIOD - 1);

  // Last valid grid column; wider positions are clamped onto it.
  localparam logic [7:0] X_MAX = 8'd159;

  localparam int SYNC_STAGES = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_P = 3'd1;
  localparam logic [2:0] ST_LOAD_E = 3'd2;
  localparam logic [2:0] ST_SHIFT  = 3'd3;
  localparam logic [2:0] ST_DRAW   = 3'd4;

  logic [2:0]             state_reg;
  logic [2:0]             state_next;
  logic [DIV_W-1:0]       div_cnt_reg;
  logic [COOL_W-1:0]      cool_cnt_reg;
  logic [EN_W-1:0]        enemy_cnt_reg;
  logic                   shot_pend_reg;
  logic                   enemy_pend_reg;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   shoot_prev_reg;
  logic [7:0]             overrun_reg;

  logic tick;
  logic shoot_rise;
  logic enemy_go;
  logic in_load_p;
  logic in_load_e;

  function automatic logic [7:0] clamp_col(input logic [7:0] x);
    return (x > X_MAX) ? X_MAX : x;
  endfunction

  assign tick       = (div_cnt_reg == DIV_LAST);
  assign shoot_rise = sync_reg[SYNC_STAGES-1] & ~shoot_prev_reg;
  // An enemy shot is only worth loading while the enemy is still alive,
  // even if the pending flag has not been cleared yet this cycle.
  assign enemy_go   = enemy_pend_reg & enemy_alive;
  assign in_load_p  = (state_reg == ST_LOAD_P);
  assign in_load_e  = (state_reg == ST_LOAD_E);

  // Free-running tick divider, wraps at TICK_DIV-1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt_reg <= '0;
    end else if (tick) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  // Two-flop synchronizer on the raw fire switch plus edge-detect history.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_reg       <= '0;
      shoot_prev_reg <= 1'b0;
    end else begin
      sync_reg       <= {sync_reg[SYNC_STAGES-2:0], shoot};
      shoot_prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  // Player shot request and cooldown; servicing the shot wins over a new edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shot_pend_reg <= 1'b0;
      cool_cnt_reg  <= '0;
    end else begin
      if (in_load_p) begin
        shot_pend_reg <= 1'b0;
      end else if (shoot_rise && (cool_cnt_reg == '0)) begin
        shot_pend_reg <= 1'b1;
      end

      if (in_load_p) begin
        cool_cnt_reg <= COOL_LOAD;
      end else if (tick && (cool_cnt_reg != '0)) begin
        cool_cnt_reg <= cool_cnt_reg - 1'b1;
      end
    end
  end

  // Enemy fire cadence: counts ticks while alive, parks when the enemy is dead.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      enemy_cnt_reg  <= EN_LOAD;
      enemy_pend_reg <= 1'b0;
    end else if (!enemy_alive) begin
      enemy_pend_reg <= 1'b0;
      if (tick) begin
        enemy_cnt_reg <= EN_LOAD;
      end
    end else begin
      if (in_load_e) begin
        enemy_pend_reg <= 1'b0;
      end
      if (tick) begin
        if (enemy_cnt_reg == '0) begin
          enemy_cnt_reg  <= EN_LOAD;
          enemy_pend_reg <= 1'b1;
        end else begin
          enemy_cnt_reg <= enemy_cnt_reg - 1'b1;
        end
      end
    end
  end

  // Dropped-tick counter: any tick that finds the sequencer busy is lost.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overrun_reg <= '0;
    end else if (tick && (state_reg != ST_IDLE) && (overrun_reg != 8'hFF)) begin
      overrun_reg <= overrun_reg + 1'b1;
    end
  end

  // Sequencer next-state: loads first, then exactly one shift, then draw.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (tick) begin
          if (shot_pend_reg) begin
            state_next = ST_LOAD_P;
          end else if (enemy_go) begin
            state_next = ST_LOAD_E;
          end else begin
            state_next = ST_SHIFT;
          end
        end
      end
      ST_LOAD_P: state_next = enemy_go ? ST_LOAD_E : ST_SHIFT;
      ST_LOAD_E: state_next = ST_SHIFT;
      ST_SHIFT:  state_next = ST_DRAW;
      ST_DRAW:   state_next = draw_done ? ST_IDLE : ST_DRAW;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Strobes decode straight from state so reset silences them immediately.
  always_comb begin
    load_x = 8'd0;
    if (in_load_p) begin
      load_x = clamp_col(user_x);
    end else if (in_load_e) begin
      load_x = clamp_col(enemy_x);
    end
  end

  assign load_en      = in_load_p | in_load_e;
  assign load_top     = in_load_e;
  assign gridUpdateEn = (state_reg == ST_SHIFT);
  assign draw_start   = (state_reg == ST_DRAW);
  assign busy         = (state_reg != ST_IDLE);
  assign overrun_cnt  = overrun_reg;

endmodule

// File: tb/tb_grid_tick_scheduler.sv
// Directed bench for grid_tick_scheduler with TICK_DIV=16, COOLDOWN=8,
// ENEMY_PERIOD=2. Tick k is serviced starting at cycle 16*k after reset.
module tb_grid_tick_scheduler;

  logic       clock;
  logic       reset;
  logic       shoot;
  logic [7:0] user_x;
  logic [7:0] enemy_x;
  logic       enemy_alive;
  logic       draw_done;
  logic       gridUpdateEn;
  logic       load_en;
  logic [7:0] load_x;
  logic       load_top;
  logic       draw_start;
  logic       busy;
  logic [7:0] overrun_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int load_pulses = 0;
  int upd_pulses  = 0;

  typedef struct {
    bit         fire;
    logic [7:0] ux;
    logic [7:0] ex;
    bit         alive;
    int         nload;
    logic [7:0] x0;
    bit         t0;
    logic [7:0] x1;
    bit         t1;
  } vec_t;

  vec_t vecs[1:23];

  grid_tick_scheduler #(
    .TICK_DIV(16),
    .COOLDOWN(8),
    .ENEMY_PERIOD(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .shoot(shoot),
    .user_x(user_x),
    .enemy_x(enemy_x),
    .enemy_alive(enemy_alive),
    .draw_done(draw_done),
    .gridUpdateEn(gridUpdateEn),
    .load_en(load_en),
    .load_x(load_x),
    .load_top(load_top),
    .draw_start(draw_start),
    .busy(busy),
    .overrun_cnt(overrun_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Cycle index since reset release; matches the DUT divider phase.
  always @(posedge clock) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Strobe counters over the whole run (used to catch stray pulses).
  always @(negedge clock) begin
    if (!reset) begin
      if (load_en)      load_pulses <= load_pulses + 1;
      if (gridUpdateEn) upd_pulses  <= upd_pulses + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_until(input int t);
    int guard = 0;
    while (cyc < t && guard < 4000) begin
      @(negedge clock);
      guard++;
    end
    if (cyc != t) begin
      total++;
      bad++;
      $display("FAIL wait_cycle: got %0d expected %0d", cyc, t);
    end
  endtask

  task automatic setv(input int k, input bit fire, input int ux, input int ex,
                      input int n, input int x0, input bit t0, input int x1, input bit t1);
    vecs[k].fire  = fire;
    vecs[k].ux    = 8'(ux);
    vecs[k].ex    = 8'(ex);
    vecs[k].nload = n;
    vecs[k].x0    = 8'(x0);
    vecs[k].t0    = t0;
    vecs[k].x1    = 8'(x1);
    vecs[k].t1    = t1;
  endtask

  task automatic run_vec(input int k);
    int base = 16 * k;
    int n    = vecs[k].nload;
    wait_until(base - 12);
    user_x      = vecs[k].ux;
    enemy_x     = vecs[k].ex;
    enemy_alive = vecs[k].alive;
    if (vecs[k].fire) begin
      wait_until(base - 10);
      shoot = 1'b1;
      wait_until(base - 7);
      shoot = 1'b0;
    end
    wait_until(base - 1);
    chk("pre_busy", busy, 0);
    chk("pre_upd", gridUpdateEn, 0);
    for (int j = 0; j < n; j++) begin
      wait_until(base + j);
      chk("load_en", load_en, 1);
      chk("load_x", load_x, (j == 0) ? vecs[k].x0 : vecs[k].x1);
      chk("load_top", load_top, (j == 0) ? vecs[k].t0 : vecs[k].t1);
      chk("upd_during_load", gridUpdateEn, 0);
    end
    wait_until(base + n);
    chk("shift_upd", gridUpdateEn, 1);
    chk("shift_load_en", load_en, 0);
    chk("shift_load_x", load_x, 0);
    chk("shift_load_top", load_top, 0);
    wait_until(base + n + 1);
    chk("draw_start", draw_start, 1);
    chk("draw_upd", gridUpdateEn, 0);
    wait_until(base + n + 2);
    chk("idle_busy", busy, 0);
    chk("idle_draw_start", draw_start, 0);
    $display("tick %0d fire=%0d alive=%0d ux=%0d ex=%0d loads=%0d",
             k, vecs[k].fire, vecs[k].alive, vecs[k].ux, vecs[k].ex, n);
  endtask

  initial begin
    reset       = 1'b1;
    shoot       = 1'b0;
    user_x      = 8'd0;
    enemy_x     = 8'd0;
    enemy_alive = 1'b0;
    draw_done   = 1'b1;

    // Default: quiet ticks; enemy alive on ticks 13..22.
    for (int k = 1; k <= 23; k++) begin
      setv(k, 1'b0, 0, 0, 0, 0, 1'b0, 0, 1'b0);
      vecs[k].alive = (k >= 13 && k <= 22);
    end
    setv(3,  1'b1, 42,  0,   1, 42,  1'b0, 0,   1'b0);  // player shot
    setv(5,  1'b1, 50,  0,   0, 0,   1'b0, 0,   1'b0);  // cooldown blocks
    setv(11, 1'b1, 77,  0,   0, 0,   1'b0, 0,   1'b0);  // cool_cnt still 1
    setv(12, 1'b1, 160, 0,   1, 159, 1'b0, 0,   1'b0);  // cooldown over, clamp
    setv(15, 1'b0, 0,   200, 1, 159, 1'b1, 0,   1'b0);  // enemy, clamp
    setv(17, 1'b0, 0,   7,   1, 7,   1'b1, 0,   1'b0);
    setv(19, 1'b0, 0,   159, 1, 159, 1'b1, 0,   1'b0);
    setv(21, 1'b1, 10,  200, 2, 10,  1'b0, 159, 1'b1);  // both
    for (int k = 13; k <= 22; k++) vecs[k].alive = 1'b1;
    vecs[23].alive = 1'b0;  // drop while enemy_pend set at tick 22

    repeat (3) @(negedge clock);
    chk("rst_upd", gridUpdateEn, 0);
    chk("rst_load_en", load_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_draw_start", draw_start, 0);
    chk("rst_overrun", overrun_cnt, 0);
    reset = 1'b0;

    for (int k = 1; k <= 23; k++) run_vec(k);

    wait_until(372);
    chk("load_pulse_count", load_pulses, 7);
    chk("upd_pulse_count", upd_pulses, 23);
    chk("overrun_after_table", overrun_cnt, 0);

    // Draw handshake held off: ticks 25 and 26 are dropped.
    draw_done = 1'b0;
    wait_until(384);
    chk("hs_upd", gridUpdateEn, 1);
    wait_until(390);
    chk("hs_draw_start", draw_start, 1);
    chk("hs_busy", busy, 1);
    wait_until(400);
    chk("hs_drop1_upd", gridUpdateEn, 0);
    wait_until(416);
    chk("hs_drop2_upd", gridUpdateEn, 0);
    wait_until(420);
    chk("hs_overrun", overrun_cnt, 2);
    chk("hs_draw_hold", draw_start, 1);
    wait_until(424);
    draw_done = 1'b1;
    wait_until(425);
    chk("hs_release_busy", busy, 0);
    chk("hs_release_draw", draw_start, 0);
    wait_until(432);
    chk("hs_next_tick_upd", gridUpdateEn, 1);
    $display("seq draw handshake: overrun=%0d", overrun_cnt);

    // Tick coinciding with the DRAW->IDLE transition is an overrun.
    draw_done = 1'b0;
    wait_until(440);
    chk("edge_draw_start", draw_start, 1);
    wait_until(447);
    draw_done = 1'b1;
    wait_until(448);
    chk("edge_busy", busy, 0);
    chk("edge_upd", gridUpdateEn, 0);
    chk("edge_overrun", overrun_cnt, 3);
    wait_until(464);
    chk("edge_next_upd", gridUpdateEn, 1);
    $display("seq draw-exit tick: overrun=%0d", overrun_cnt);

    // Reset while in DRAW with a shot pending.
    draw_done = 1'b0;
    user_x    = 8'd33;
    wait_until(466);
    shoot = 1'b1;
    wait_until(469);
    shoot = 1'b0;
    wait_until(480);
    chk("pend_drop_upd", gridUpdateEn, 0);
    chk("pend_drop_overrun", overrun_cnt, 4);
    wait_until(482);
    chk("pre_reset_draw", draw_start, 1);
    wait_until(484);
    reset = 1'b1;
    #1;
    chk("async_draw_start", draw_start, 0);
    chk("async_busy", busy, 0);
    chk("async_overrun", overrun_cnt, 0);
    chk("async_upd", gridUpdateEn, 0);
    chk("async_load_en", load_en, 0);
    chk("async_load_x", load_x, 0);
    chk("async_load_top", load_top, 0);
    repeat (2) @(negedge clock);
    draw_done = 1'b1;
    reset     = 1'b0;
    wait_until(15);
    chk("post_rst_busy", busy, 0);
    wait_until(16);
    chk("post_rst_load_en", load_en, 0);
    chk("post_rst_upd", gridUpdateEn, 1);
    wait_until(17);
    chk("post_rst_draw", draw_start, 1);
    $display("seq reset mid-draw: first tick load_en=%0d", load_en);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/grid_tick_scheduler.md
# grid_tick_scheduler

Frame-rate sequencer for the 160-column bullet shifter grid. Divides the 50 MHz clock into game ticks and, once per tick, injects any pending player or enemy shot into the grid's load path. It then issues a single one-cycle `gridUpdateEn` shift pulse and hands the frame to the VGA drawer through a start/done handshake. It sits between the switch/position inputs and the grid datapath and is the only source of `gridUpdateEn`.

## Interface
- `TICK_DIV`, 833333 — clock cycles per game tick (60 Hz at 50 MHz); legal range ≥ 8.
- `COOLDOWN`, 8 — ticks after a player shot during which new shots are ignored.
- `ENEMY_PERIOD`, 30 — ticks between enemy shots while `enemy_alive`.
- `clock`, in, 1 — 50 MHz system clock.
- `reset`, in, 1 — asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `shoot`, in, 1 — raw player fire switch level (asynchronous to `clock`).
- `user_x`, in, 8 — player column.
- `enemy_x`, in, 8 — enemy column.
- `enemy_alive`, in, 1 — enables enemy fire.
- `draw_done`, in, 1 — drawer finished the current frame (level, sampled).
- `gridUpdateEn`, out, 1 — one-cycle shift pulse to the grid.
- `load_en`, out, 1 — one-cycle column load strobe.
- `load_x`, out, 8 — column to load, valid with `load_en`.
- `load_top`, out, 1 — 0 = player row (bottom), 1 = enemy row (top); valid with `load_en`.
- `draw_start`, out, 1 — frame ready; held until `draw_done` is seen.
- `busy`, out, 1 — FSM not in IDLE.
- `overrun_cnt`, out, 8 — saturating count of dropped ticks.

## Operation
- **Shoot input:** 2-flop synchronizer, then rising-edge detect. An edge sets `shot_pend` only if `cool_cnt == 0`. An edge while `shot_pend` is already set is ignored.
- **Tick counter:** `div_cnt` counts 0..TICK_DIV-1 and wraps. `tick` is high for the one cycle where `div_cnt == TICK_DIV-1`.
- **Counters updated on each `tick`:**
  - `cool_cnt` decrements if nonzero.
  - If `enemy_alive`, `enemy_cnt` decrements; at 0 it reloads to ENEMY_PERIOD-1 and sets `enemy_pend`.
  - If `!enemy_alive`, `enemy_cnt` holds at ENEMY_PERIOD-1 and `enemy_pend` clears.
- **FSM states:** IDLE, LOAD_P, LOAD_E, SHIFT, DRAW.
  - IDLE + `tick` → LOAD_P if `shot_pend`, else LOAD_E if `enemy_pend`, else SHIFT.
  - LOAD_P (1 cycle):
    - `load_en=1`, `load_top=0`, `load_x=min(user_x,159)`.
    - Clears `shot_pend`; `cool_cnt ← COOLDOWN`.
    - Next state: LOAD_E if `enemy_pend`, else SHIFT.
  - LOAD_E (1 cycle):
    - `load_en=1`, `load_top=1`, `load_x=min(enemy_x,159)`.
    - Clears `enemy_pend`; next state SHIFT.
  - SHIFT (1 cycle): `gridUpdateEn=1`; next state DRAW.
  - DRAW: `draw_start=1`; when `draw_done` is sampled high → IDLE, with `draw_start` low from the next cycle.
- **Overrun:** a `tick` arriving while not in IDLE is dropped and `overrun_cnt` increments, saturating at 255. Pending flags persist to the next accepted tick.
- **Input sampling:** `user_x` / `enemy_x` are sampled combinationally in their LOAD state only.
- `load_x` and `load_top` read 0 whenever `load_en` is 0.
- **Reset (asynchronous):**
  - All outputs 0; FSM in IDLE.
  - `div_cnt=0`, `cool_cnt=0`, `enemy_cnt=ENEMY_PERIOD-1`.
  - `shot_pend`, `enemy_pend` and synchronizer flops cleared.
  - Reset mid-frame abandons the frame with no further strobes.

## Timing
- Tick → first strobe: the FSM leaves IDLE on the cycle after `tick`.
- Both shots pending: LOAD_P, LOAD_E, SHIFT on 3 consecutive cycles, then DRAW.
- No shot pending: SHIFT on the cycle after `tick`.
- Every accepted tick gives exactly one `gridUpdateEn` pulse, always after all loads of that tick.
- Shoot edge → `shot_pend`: 3 cycles (2 sync + edge detect).
- `shot_pend` set in the same cycle as `tick` is not serviced in that tick.
- `draw_done` sampled in the first DRAW cycle still ends DRAW (minimum DRAW length 1 cycle).
- A `tick` in the same cycle as the DRAW→IDLE transition counts as overrun.
- Cooldown: after a shot on tick N, an edge is accepted again once `cool_cnt` reaches 0, i.e. from tick N+COOLDOWN onward.

## Test plan
- **Idle cadence** (TICK_DIV=16, no inputs, `draw_done` tied 1): `gridUpdateEn` pulses every 16 cycles; `load_en` never asserts; `overrun_cnt=0`.
- **Player shot** (`user_x=42`, shoot edge): next tick gives `load_en` with `load_x=42`, `load_top=0`, then `gridUpdateEn` the following cycle. A second edge 2 ticks later (COOLDOWN=8) produces no load.
- **Enemy and player together** (ENEMY_PERIOD=2, `enemy_alive=1`, `enemy_x=200`, `user_x=10`, shot pending): on the same tick, consecutive cycles show load(10, top 0), load(159, top 1), then shift.
- **Draw handshake and overrun** (`draw_done` held low for 40 cycles, TICK_DIV=16): `draw_start` stays high; `overrun_cnt=2`; after `draw_done` rises, FSM returns to IDLE and the next tick is serviced normally.
- **Reset mid-DRAW** (assert `reset` with `shot_pend` set): all outputs 0 immediately and asynchronously. After release, no load occurs on the first tick.
- **enemy_alive deassert:** dropping `enemy_alive` while `enemy_pend` is set yields no top-row load on the next tick.
